spram_arbiter: RTL

SPRAM_ARBITER -- requirements
Module: spram_arbiter

---
 rtl/spram_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/spram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with 1-cycle registered read.
// Grants and RAM drive are combinational from the requests; only the tie-break pointer and the read-return tag are stored.
module spram_arbiter #(
    parameter int unsigned AWIDTH    = 10,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned NUM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_req,
    input  logic              a_wren,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_wren,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DWIDTH-1:0] a_rdata,
    output logic [DWIDTH-1:0] b_rdata,
    output logic [AWIDTH-1:0] ram_address,
    output logic              ram_wren,
    output logic [DWIDTH-1:0] ram_data,
    input  logic [DWIDTH-1:0] ram_out
);

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    logic   last_b_q, last_b_d;
    logic   rd_pend_q, rd_pend_d;
    owner_e rd_owner_q, rd_owner_d;

    // Reset-time state makes A win the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_b_q   <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_A;
        end else begin
            last_b_q   <= last_b_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Arbitration, RAM mux and next-state; everything is held at zero while reset is asserted.
    always_comb begin
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        ram_wren    = 1'b0;
        ram_address = '0;
        ram_data    = '0;
        last_b_d    = last_b_q;
        rd_pend_d   = 1'b0;
        rd_owner_d  = rd_owner_q;

        if (resetn) begin
            a_gnt = a_req & (~b_req | last_b_q);
            b_gnt = b_req & (~a_req | ~last_b_q);
        end

        if (a_gnt) begin
            ram_wren    = a_wren;
            ram_address = a_addr;
            ram_data    = a_wdata;
            last_b_d    = 1'b0;
            rd_pend_d   = ~a_wren;
            if (!a_wren) rd_owner_d = OWN_A;
        end else if (b_gnt) begin
            ram_wren    = b_wren;
            ram_address = b_addr;
            ram_data    = b_wdata;
            last_b_d    = 1'b1;
            rd_pend_d   = ~b_wren;
            if (!b_wren) rd_owner_d = OWN_B;
        end
    end

    // Read data returns on the cycle after the grant; ram_out is shared by both requesters.
    assign a_rvalid = rd_pend_q & (rd_owner_q == OWN_A);
    assign b_rvalid = rd_pend_q & (rd_owner_q == OWN_B);
    assign a_rdata  = ram_out;
    assign b_rdata  = ram_out;

    // Requesters must keep addresses inside the RAM.
    addr_in_range_a : assert property (@(posedge clk) disable iff (!resetn)
        (a_gnt | b_gnt) |-> (32'(ram_address) < NUM_WORDS));

endmodule
